// File: rtl/vending_session_ctrl_if.sv
// Handshake/status bundle for the ticket vending session controller.
// The master side drives requests, coins and acks; the slave side is the controller.
interface vending_session_ctrl_if;
  logic       start;
  logic [2:0] origin;
  logic [2:0] destination;
  logic [3:0] tickets;
  logic       cancel;
  logic       coin_valid;
  logic [6:0] coin_value;
  logic       coin_ready;
  logic       coin_reject;
  logic [4:0] fare;
  logic [7:0] total_due;
  logic [8:0] paid;
  logic       tkt_valid;
  logic       tkt_ack;
  logic       chg_valid;
  logic [5:0] chg_value;
  logic       chg_ack;
  logic       busy;
  logic       error;
  logic [2:0] state;

  modport master (
    output start, origin, destination, tickets, cancel, coin_valid, coin_value, tkt_ack, chg_ack,
    input  coin_ready, coin_reject, fare, total_due, paid, tkt_valid, chg_valid, chg_value,
           busy, error, state
  );

  modport slave (
    input  start, origin, destination, tickets, cancel, coin_valid, coin_value, tkt_ack, chg_ack,
    output coin_ready, coin_reject, fare, total_due, paid, tkt_valid, chg_valid, chg_value,
           busy, error, state
  );
endinterface

// File: rtl/vending_session_ctrl.sv
// Ticket vending session: quote a fare, collect coins, issue tickets, dispense change.
// Cancel or a payment timeout refunds everything paid so far as change.
module vending_session_ctrl #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_TICKETS = 9
) (
  input logic             clk,
  input logic             reset,
  vending_session_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_QUOTE = 3'd1, S_PAY = 3'd2, S_ISSUE = 3'd3, S_CHANGE = 3'd4, S_DONE = 3'd5
  } state_e;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

  state_e        st;
  logic [2:0]    org, dst;
  logic [3:0]    tkt, tkt_rem;
  logic [4:0]    fare;
  logic [7:0]    total_due;
  logic [8:0]    paid, chg_rem;
  logic [CW-1:0] idle_cnt;
  logic          coin_reject, tkt_valid, chg_valid, error;
  logic [5:0]    chg_value;

  // Greedy coin choice; every amount is a multiple of 5, so 5 is the floor.
  function automatic logic [5:0] pick(input logic [8:0] amt);
    if (amt >= 9'd50)      return 6'd50;
    else if (amt >= 9'd10) return 6'd10;
    else                   return 6'd5;
  endfunction

  logic [2:0] diff;
  logic [4:0] fare_calc;
  logic [7:0] due_calc;
  logic       in_ok, paid_full, timed_out, abort, coin_ready, accept, coin_ok;
  logic [8:0] chg_left, chg_nxt;

  assign diff       = (org > dst) ? (org - dst) : (dst - org);
  assign fare_calc  = ({2'b00, diff} + 5'd1) * 5'd5;
  assign due_calc   = {3'b000, fare_calc} * {4'b0000, tkt};
  assign in_ok      = (org >= 3'd1) && (org <= 3'd5) && (dst >= 3'd1) && (dst <= 3'd5) &&
                      (tkt != 4'd0) && (int'(tkt) <= MAX_TICKETS);
  assign paid_full  = paid >= {1'b0, total_due};
  assign timed_out  = idle_cnt >= TO_LIM;
  assign abort      = bus.cancel || timed_out;
  // Gating ready with abort keeps a coin offered alongside cancel from being taken.
  assign coin_ready = (st == S_PAY) && !paid_full && !abort;
  assign accept     = bus.coin_valid && coin_ready;
  assign coin_ok    = (bus.coin_value == 7'd5) || (bus.coin_value == 7'd10) ||
                      (bus.coin_value == 7'd50);
  assign chg_left   = paid - {1'b0, total_due};
  assign chg_nxt    = chg_rem - {3'b000, chg_value};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_IDLE;
      org <= '0; dst <= '0; tkt <= '0; tkt_rem <= '0;
      fare <= '0; total_due <= '0; paid <= '0; chg_rem <= '0; idle_cnt <= '0;
      coin_reject <= 1'b0; tkt_valid <= 1'b0; chg_valid <= 1'b0; chg_value <= '0; error <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (st)
        S_IDLE: if (bus.start) begin
          org <= bus.origin; dst <= bus.destination; tkt <= bus.tickets;
          error <= 1'b0; paid <= '0;
          st <= S_QUOTE;
        end
        S_QUOTE: if (!in_ok) begin
          error <= 1'b1;
          st <= S_IDLE;
        end else begin
          fare <= fare_calc; total_due <= due_calc; idle_cnt <= '0;
          st <= S_PAY;
        end
        S_PAY: if (paid_full) begin
          tkt_rem <= tkt; tkt_valid <= 1'b1;
          st <= S_ISSUE;
        end else if (abort) begin
          error <= error | timed_out;
          chg_rem <= paid;
          chg_valid <= (paid != 9'd0);
          chg_value <= (paid != 9'd0) ? pick(paid) : 6'd0;
          st <= S_CHANGE;
        end else if (accept) begin
          idle_cnt <= '0;
          if (coin_ok) paid <= paid + {2'b00, bus.coin_value};
          else         coin_reject <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        S_ISSUE: if (bus.tkt_ack) begin
          tkt_rem <= tkt_rem - 4'd1;
          if (tkt_rem == 4'd1) begin
            tkt_valid <= 1'b0;
            if (chg_left != 9'd0) begin
              chg_rem <= chg_left; chg_valid <= 1'b1; chg_value <= pick(chg_left);
              st <= S_CHANGE;
            end else begin
              st <= S_DONE;
            end
          end
        end
        S_CHANGE: if (!chg_valid) begin
          st <= S_DONE;
        end else if (bus.chg_ack) begin
          chg_rem <= chg_nxt;
          if (chg_nxt == 9'd0) begin
            chg_valid <= 1'b0; chg_value <= '0;
            st <= S_DONE;
          end else begin
            chg_value <= pick(chg_nxt);
          end
        end
        S_DONE:  st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.coin_ready  = coin_ready;
  assign bus.coin_reject = coin_reject;
  assign bus.fare        = fare;
  assign bus.total_due   = total_due;
  assign bus.paid        = paid;
  assign bus.tkt_valid   = tkt_valid;
  assign bus.chg_valid   = chg_valid;
  assign bus.chg_value   = chg_value;
  assign bus.busy        = (st != S_IDLE);
  assign bus.error       = error;
  assign bus.state       = st;
endmodule

// File: tb/tb_vending_session_ctrl.sv
// Scoreboard bench for vending_session_ctrl: stimulus queues expected session
// summaries and change coins, a negedge monitor pops and compares them.
module tb_vending_session_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vending_session_ctrl_if bus();
  vending_session_ctrl #(.TIMEOUT_CYC(1000), .MAX_TICKETS(9)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int fare; int due; int paid; int err; bit chk_price;
    int ntkt; int nchg; int nrej; int cr;
  } sess_t;

  sess_t exp_q[$];
  int    exp_chg[$];
  int    total = 0;
  int    bad   = 0;
  bit    ack_en = 1'b1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic sess_t mk(input int f, input int d, input int p, input int er, input bit ck,
                               input int nt, input int nc, input int nr, input int cr);
    sess_t r;
    r.fare = f; r.due = d; r.paid = p; r.err = er; r.chk_price = ck;
    r.ntkt = nt; r.nchg = nc; r.nrej = nr; r.cr = cr;
    return r;
  endfunction

  // Ack responder: acks every other cycle so valids are sometimes held.
  initial begin
    bit tgl = 1'b0;
    bus.tkt_ack = 1'b0; bus.chg_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      tgl = ~tgl;
      bus.tkt_ack = ack_en && bus.tkt_valid && tgl;
      bus.chg_ack = bus.chg_valid && tgl;
    end
  end

  // Monitor: counts handshakes per session and scores it on return to IDLE.
  initial begin
    int ntkt = 0, nchg = 0, nrej = 0, cr = 0;
    int prev = 0;
    sess_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ntkt = 0; nchg = 0; nrej = 0; cr = 0; prev = 0;
      end else begin
        if (bus.tkt_valid && bus.tkt_ack) ntkt++;
        if (bus.chg_valid && bus.chg_ack) begin
          nchg++;
          if (exp_chg.size() == 0) check("chg_unexpected", int'(bus.chg_value), 0);
          else check("chg_value", int'(bus.chg_value), exp_chg.pop_front());
        end
        if (bus.coin_reject) nrej++;
        if (bus.coin_ready) cr = 1;
        if (prev != 0 && bus.state == 3'd0) begin
          if (exp_q.size() == 0) begin
            check("session_unexpected", prev, 0);
          end else begin
            e = exp_q.pop_front();
            if (e.chk_price) begin
              check("fare", int'(bus.fare), e.fare);
              check("total_due", int'(bus.total_due), e.due);
            end
            check("paid", int'(bus.paid), e.paid);
            check("error", int'(bus.error), e.err);
            check("tickets_issued", ntkt, e.ntkt);
            check("change_coins", nchg, e.nchg);
            check("coin_rejects", nrej, e.nrej);
            check("coin_ready_seen", cr, e.cr);
          end
          ntkt = 0; nchg = 0; nrej = 0; cr = 0;
        end
        prev = int'(bus.state);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_session(input int o, input int d, input int t, input bit lat_chk,
                               input int due);
    bus.start = 1'b1;
    bus.origin = 3'(o); bus.destination = 3'(d); bus.tickets = 4'(t);
    tick();
    bus.start = 1'b0;
    if (lat_chk) begin
      tick(); tick();
      check("latency_state_pay", int'(bus.state), 2);
      check("latency_total_due", int'(bus.total_due), due);
    end
  endtask

  task automatic coin(input int v);
    int n = 0;
    while (!bus.coin_ready && n < 100) begin tick(); n++; end
    if (!bus.coin_ready) begin
      check("coin_ready_wait", int'(bus.coin_ready), 1);
    end else begin
      bus.coin_valid = 1'b1; bus.coin_value = 7'(v);
      tick();
      bus.coin_valid = 1'b0; bus.coin_value = '0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.state != 3'd0 && n < 3000) begin tick(); n++; end
    check("wait_idle", int'(bus.state), 0);
    tick(); tick();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    bus.start = 1'b0; bus.origin = '0; bus.destination = '0; bus.tickets = '0;
    bus.cancel = 1'b0; bus.coin_valid = 1'b0; bus.coin_value = '0;
    tick(); tick();
    check("rst_state", int'(bus.state), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_paid", int'(bus.paid), 0);
    check("rst_coin_ready", int'(bus.coin_ready), 0);
    reset = 1'b1;
    tick();

    // 2->5 x2, exact payment
    exp_q.push_back(mk(20, 40, 40, 0, 1, 2, 0, 0, 1));
    start_session(2, 5, 2, 1, 40);
    coin(10); coin(10); coin(10); coin(10);
    wait_idle();

    // 1->5 x3, partial payment then cancel
    exp_q.push_back(mk(25, 75, 20, 0, 1, 0, 2, 0, 1));
    exp_chg.push_back(10); exp_chg.push_back(10);
    start_session(1, 5, 3, 1, 75);
    coin(10); coin(10);
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    wait_idle();

    // 1->4 x2, overpayment with change
    exp_q.push_back(mk(20, 40, 70, 0, 1, 2, 3, 0, 1));
    exp_chg.push_back(10); exp_chg.push_back(10); exp_chg.push_back(10);
    start_session(1, 4, 2, 1, 40);
    coin(10); coin(10); coin(50);
    wait_idle();

    // Out-of-range requests
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    start_session(0, 3, 1, 0, 0);
    wait_idle();
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    start_session(1, 2, 0, 0, 0);
    wait_idle();
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    start_session(1, 6, 1, 0, 0);
    wait_idle();
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    start_session(2, 3, 10, 0, 0);
    wait_idle();

    // Cancel beats a coin in the same cycle; error cleared by new start
    exp_q.push_back(mk(25, 25, 5, 0, 1, 0, 1, 0, 1));
    exp_chg.push_back(5);
    start_session(5, 1, 1, 1, 25);
    coin(5);
    bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_value = 7'd50;
    #1 check("cancel_blocks_ready", int'(bus.coin_ready), 0);
    tick();
    bus.cancel = 1'b0; bus.coin_valid = 1'b0; bus.coin_value = '0;
    wait_idle();

    // Max tickets, largest paid, change 45 -> 10,10,10,10,5
    exp_q.push_back(mk(25, 225, 270, 0, 1, 9, 5, 0, 1));
    exp_chg.push_back(10); exp_chg.push_back(10); exp_chg.push_back(10);
    exp_chg.push_back(10); exp_chg.push_back(5);
    start_session(1, 5, 9, 1, 225);
    coin(50); coin(50); coin(50); coin(50); coin(10); coin(10); coin(50);
    wait_idle();

    // Bad coin then timeout refund
    exp_q.push_back(mk(5, 20, 10, 1, 1, 0, 1, 1, 1));
    exp_chg.push_back(10);
    start_session(3, 3, 4, 1, 20);
    coin(7);
    check("reject_paid_unchanged", int'(bus.paid), 0);
    coin(10);
    wait_idle();

    // Reset during ISSUE with tkt_valid held high
    ack_en = 1'b0;
    start_session(1, 2, 3, 1, 30);
    coin(10); coin(10); coin(10);
    n = 0;
    while (!bus.tkt_valid && n < 50) begin tick(); n++; end
    check("issue_tkt_valid", int'(bus.tkt_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", int'(bus.state), 0);
    check("async_rst_tkt_valid", int'(bus.tkt_valid), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_paid", int'(bus.paid), 0);
    check("async_rst_total_due", int'(bus.total_due), 0);
    check("async_rst_fare", int'(bus.fare), 0);
    check("async_rst_chg_valid", int'(bus.chg_valid), 0);
    tick(); tick();
    reset = 1'b1;
    ack_en = 1'b1;
    tick();

    // Normal operation after reset
    exp_q.push_back(mk(5, 5, 5, 0, 1, 1, 0, 0, 1));
    start_session(4, 4, 1, 1, 5);
    coin(5);
    wait_idle();

    check("scoreboard_drained", exp_q.size() + exp_chg.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
